// File: rtl/sr_loader_pkg.sv
// Shared types and constants for the schoolRISCV program loader.
package sr_loader_pkg;

  typedef enum logic [1:0] {LOAD, START, RUN} loader_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] SR_NOP = 32'h0000_0013;

endpackage

// File: rtl/sr_loader_mem.sv
// Instruction memory: one synchronous write port, one asynchronous read port, no reset.
module sr_loader_mem #(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sr_program_loader.sv
// Loads instruction memory from a byte stream, holds the CPU in reset meanwhile,
// then serves instruction words, masking anything beyond the loaded program with NOP.
module sr_program_loader
  import sr_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_byte,
  input  logic            in_last,
  input  logic            reload,
  input  logic [31:0]     imAddr,
  output logic [31:0]     imData,
  output logic            cpu_rst,
  output logic [ADDR_W:0] word_count,
  output logic            overflow
);

  loader_state_t   state_q, state_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [ADDR_W:0] word_count_q, word_count_d;
  logic            overflow_q, overflow_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     merged;
  logic            we;
  logic            full;
  logic [31:0]     rdata;

  assign full   = (word_count_q == (ADDR_W + 1)'(DEPTH));
  // Unfilled lanes are already zero, so OR-ing in the new byte yields the word to write.
  assign merged = asm_q | ({24'b0, in_byte} << {byte_idx_q, 3'b000});

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    asm_d        = asm_q;
    we           = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (full) begin
            overflow_d = 1'b1;
          end else if (byte_idx_q == 2'd3 || in_last) begin
            we           = 1'b1;
            word_count_d = word_count_q + 1'b1;
            byte_idx_d   = 2'd0;
            asm_d        = 32'b0;
          end else begin
            asm_d      = merged;
            byte_idx_d = byte_idx_q + 2'd1;
          end
          if (in_last) state_d = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (reload) begin
          state_d      = LOAD;
          byte_idx_d   = 2'd0;
          word_count_d = '0;
          overflow_d   = 1'b0;
          asm_d        = 32'b0;
        end
      end
      default: state_d = LOAD;
    endcase
    cpu_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      byte_idx_q   <= 2'd0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      cpu_rst_q    <= 1'b1;
      asm_q        <= 32'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      cpu_rst_q    <= cpu_rst_d;
      asm_q        <= asm_d;
    end
  end

  sr_loader_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(word_count_q[ADDR_W-1:0]),
    .wdata(merged),
    .raddr(imAddr[ADDR_W-1:0]),
    .rdata(rdata)
  );

  // Full-width compare: high address bits can never alias into the array.
  assign imData     = (imAddr < {{(31 - ADDR_W){1'b0}}, word_count_q}) ? rdata : SR_NOP;
  assign in_ready   = (state_q == LOAD);
  assign cpu_rst    = cpu_rst_q;
  assign word_count = word_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sr_program_loader.sv
// Directed bench for sr_program_loader (DEPTH=4) with an expected-word scoreboard.
module tb_sr_program_loader;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_byte;
  logic            in_last;
  logic            reload;
  logic [31:0]     imAddr;
  logic [31:0]     imData;
  logic            cpu_rst;
  logic [ADDR_W:0] word_count;
  logic            overflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  sr_program_loader #(
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .reload    (reload),
    .imAddr    (imAddr),
    .imData    (imData),
    .cpu_rst   (cpu_rst),
    .word_count(word_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Pop each expected word and compare it against the read port at consecutive addresses.
  task automatic drain(input string tag);
    int unsigned a;
    logic [31:0] w;
    a = 0;
    while (exp_q.size() > 0) begin
      w      = exp_q.pop_front();
      imAddr = a;
      #1;
      check($sformatf("%s_word%0d", tag, a), imData, w);
      a++;
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; reload = 1'b0;
    imAddr = 32'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_imdata", imData, NOP);

    // Two full words
    exp_q.push_back(32'h0050_0013);
    exp_q.push_back(32'h0010_0093);
    send(8'h13, 0); send(8'h00, 0); send(8'h50, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 1);
    check("t1_start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t1_start_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("t1_run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("t1_run_in_ready", 32'(in_ready), 32'd0);
    check("t1_word_count", 32'(word_count), 32'd2);
    drain("t1");
    imAddr = 32'd2; #1;
    check("t1_nop_addr2", imData, NOP);
    imAddr = 32'h0000_0100; #1;
    check("t1_nop_high", imData, NOP);

    // Reload with a byte offered in the same cycle: that byte must not be taken
    reload = 1'b1; in_valid = 1'b1; in_byte = 8'h55;
    tick();
    reload = 1'b0; in_valid = 1'b0;
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t4_word_count", 32'(word_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      imAddr = i; #1;
      check($sformatf("t4_nop%0d", i), imData, NOP);
    end

    // Partial final word
    exp_q.push_back(32'hDDCC_BBAA);
    exp_q.push_back(32'h0000_2211);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    send(8'h11, 0); send(8'h22, 1);
    tick();
    check("t2_cpu_rst", 32'(cpu_rst), 32'd0);
    check("t2_word_count", 32'(word_count), 32'd2);
    check("t2_overflow", 32'(overflow), 32'd0);
    drain("t2");

    // Reset mid-word, then a fresh load must start at lane 0 of address 0
    do_reload();
    send(8'hEE, 0); send(8'hFF, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_word_count", 32'(word_count), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    exp_q.push_back(32'h0403_0201);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    tick();
    check("t5_word_count_after", 32'(word_count), 32'd1);
    drain("t5");
    imAddr = 32'd1; #1;
    check("t5_stale_masked", imData, NOP);

    // Overflow: 20 bytes into a 4-word memory
    do_reload();
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0 && i < 16)
        exp_q.push_back({8'(i + 8'h13), 8'(i + 8'h12), 8'(i + 8'h11), 8'(i + 8'h10)});
      send(8'(i + 8'h10), i == 19);
      if (i == 15) check("t3_no_overflow_16", 32'(overflow), 32'd0);
      if (i == 16) check("t3_overflow_17", 32'(overflow), 32'd1);
    end
    tick();
    check("t3_word_count", 32'(word_count), 32'd4);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    check("t3_cpu_rst", 32'(cpu_rst), 32'd0);
    drain("t3");
    imAddr = 32'd4; #1;
    check("t3_nop_addr4", imData, NOP);
    imAddr = 32'h8000_0000; #1;
    check("t3_nop_high", imData, NOP);

    // Reload is ignored outside RUN
    do_reload();
    reload = 1'b1;
    send(8'h77, 1);
    reload = 1'b0;
    check("ign_start_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("ign_run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("ign_word_count", 32'(word_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
